// File: rtl/clock_set_controller.sv
// clock_set_controller: set-mode sequencer that edits time/date/alarm fields and commits them to the time base
// Ports: clock, reset_n (sync, active-low); set/incr/dcr level buttons; tick_1hz edit-timeout tick;
//   hours/mins/secs/day/month/year live fields; run_en pauses the time base while editing h/m/s;
//   wr_en/wr_sel/wr_data one-cycle commit strobe; edit_val/mode for display; alarm_hours alarm register.
module clock_set_controller #(
  parameter int TIMEOUT_TICKS = 30,
  parameter int YEAR_MIN = 2000,
  parameter int YEAR_MAX = 2099
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        set,
  input  logic        incr,
  input  logic        dcr,
  input  logic        tick_1hz,
  input  logic [4:0]  hours,
  input  logic [5:0]  mins,
  input  logic [5:0]  secs,
  input  logic [4:0]  day,
  input  logic [3:0]  month,
  input  logic [11:0] year,
  output logic        run_en,
  output logic        wr_en,
  output logic [2:0]  wr_sel,
  output logic [11:0] wr_data,
  output logic [11:0] edit_val,
  output logic [2:0]  mode,
  output logic [4:0]  alarm_hours
);
  typedef enum logic [2:0] {RUN, HOUR, MIN, SEC, DAY, MONTH, YEAR, ALARM} state_t;
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  state_t state_q, state_d, nxt;
  logic set_q, incr_q, dcr_q, set_e, incr_e, dcr_e, any_e, field, tmo;
  logic clamp_q, clamp_d, wr_en_q, wr_en_d;
  logic [11:0] edit_q, edit_d, lo, hi, ld, wr_data_q, wr_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] alarm_q, alarm_d, dim_live, dim_new, clamp_dim_q, clamp_dim_d;
  logic [2:0] wr_sel_q, wr_sel_d;
  function automatic logic [4:0] dim_f(input logic [3:0] m, input logic [11:0] y);
    return (m == 4'd2) ? ((y[1:0] == 2'd0) ? 5'd29 : 5'd28) :
           (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
  endfunction
  assign set_e = set & ~set_q;
  assign incr_e = incr & ~incr_q;
  assign dcr_e = dcr & ~dcr_q;
  assign any_e = set_e | incr_e | dcr_e;
  assign field = state_q != RUN;
  assign nxt = state_t'(state_q + 3'd1);
  assign dim_live = dim_f(month, year);
  // month/year that will be live once the pending MONTH or YEAR commit lands
  assign dim_new = (state_q == MONTH) ? dim_f(edit_q[3:0], year) : dim_f(month, edit_q);
  assign tmo = field && tick_1hz && !any_e && cnt_q == CW'(TIMEOUT_TICKS - 1);
  assign lo = (state_q == DAY || state_q == MONTH) ? 12'd1 : (state_q == YEAR) ? 12'(YEAR_MIN) : 12'd0;
  assign hi = (state_q == HOUR || state_q == ALARM) ? 12'd23 :
              (state_q == MIN || state_q == SEC) ? 12'd59 :
              (state_q == DAY) ? {7'd0, dim_live} :
              (state_q == MONTH) ? 12'd12 :
              (state_q == YEAR) ? 12'(YEAR_MAX) : 12'd0;
  assign ld = (nxt == HOUR) ? {7'd0, hours} :
              (nxt == MIN) ? {6'd0, mins} :
              (nxt == SEC) ? {6'd0, secs} :
              (nxt == DAY) ? {7'd0, day} :
              (nxt == MONTH) ? {8'd0, month} :
              (nxt == YEAR) ? year :
              (nxt == ALARM) ? {7'd0, alarm_q} : edit_q;
  always_comb begin
    state_d = state_q;
    edit_d = edit_q;
    cnt_d = cnt_q;
    alarm_d = alarm_q;
    clamp_d = 1'b0;
    clamp_dim_d = clamp_dim_q;
    // a pending day clamp issues its write the cycle after the MONTH/YEAR strobe
    wr_en_d = clamp_q;
    wr_sel_d = clamp_q ? 3'd4 : wr_sel_q;
    wr_data_d = clamp_q ? {7'd0, clamp_dim_q} : wr_data_q;
    if (set_e) begin
      state_d = nxt;
      edit_d = ld;
      cnt_d = '0;
      if (field) begin
        wr_en_d = 1'b1;
        wr_sel_d = state_q;
        wr_data_d = edit_q;
      end
      if (state_q == ALARM) alarm_d = edit_q[4:0];
      if ((state_q == MONTH || state_q == YEAR) && day > dim_new) begin
        clamp_d = 1'b1;
        clamp_dim_d = dim_new;
      end
    end else if (field) begin
      cnt_d = any_e ? '0 : tick_1hz ? cnt_q + 1'b1 : cnt_q;
      if (tmo) begin
        state_d = RUN;
        cnt_d = '0;
      end else if (incr_e && !dcr_e) edit_d = (edit_q >= hi) ? lo : edit_q + 12'd1;
      else if (dcr_e && !incr_e) edit_d = (edit_q <= lo) ? hi : edit_q - 12'd1;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= RUN;
      edit_q <= '0;
      cnt_q <= '0;
      alarm_q <= '0;
      clamp_q <= 1'b0;
      clamp_dim_q <= '0;
      wr_en_q <= 1'b0;
      wr_sel_q <= '0;
      wr_data_q <= '0;
      set_q <= 1'b0;
      incr_q <= 1'b0;
      dcr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      edit_q <= edit_d;
      cnt_q <= cnt_d;
      alarm_q <= alarm_d;
      clamp_q <= clamp_d;
      clamp_dim_q <= clamp_dim_d;
      wr_en_q <= wr_en_d;
      wr_sel_q <= wr_sel_d;
      wr_data_q <= wr_data_d;
      set_q <= set;
      incr_q <= incr;
      dcr_q <= dcr;
    end
  end
  assign run_en = !(state_q == HOUR || state_q == MIN || state_q == SEC);
  assign wr_en = wr_en_q;
  assign wr_sel = wr_sel_q;
  assign wr_data = wr_data_q;
  assign edit_val = edit_q;
  assign mode = state_q;
  assign alarm_hours = alarm_q;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: model-checked directed bench for clock_set_controller
module tb_clock_set_controller;
  logic clock = 0, reset_n = 0, set = 0, incr = 0, dcr = 0, tick_1hz = 0;
  logic [4:0] hours = 0, day = 1;
  logic [5:0] mins = 0, secs = 0;
  logic [3:0] month = 1;
  logic [11:0] year = 2000;
  logic run_en, wr_en;
  logic [2:0] wr_sel, mode;
  logic [11:0] wr_data, edit_val;
  logic [4:0] alarm_hours;
  clock_set_controller dut (
    .clock(clock), .reset_n(reset_n), .set(set), .incr(incr), .dcr(dcr), .tick_1hz(tick_1hz),
    .hours(hours), .mins(mins), .secs(secs), .day(day), .month(month), .year(year),
    .run_en(run_en), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .edit_val(edit_val), .mode(mode), .alarm_hours(alarm_hours)
  );
  always #5 clock = ~clock;
  int tests = 0, fails = 0;
  int m_mode, m_edit, m_alarm, m_cnt, m_clamp, m_sel, m_data;
  bit m_wr, p_set, p_incr, p_dcr;
  int ws[$], wd[$];
  int dtab[1:12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
  int seq_d[7] = '{5, 17, 42, 31, 1, 2023, 0};
  function automatic int dim_of(int m, int y);
    return (m == 2 && y % 4 == 0) ? 29 : dtab[m];
  endfunction
  function automatic int live_of(int md);
    case (md)
      1: return hours;
      2: return mins;
      3: return secs;
      4: return day;
      5: return month;
      6: return year;
      7: return m_alarm;
      default: return 0;
    endcase
  endfunction
  function automatic int lo_of(int md);
    return (md == 4 || md == 5) ? 1 : (md == 6) ? 2000 : 0;
  endfunction
  function automatic int hi_of(int md);
    case (md)
      1, 7: return 23;
      2, 3: return 59;
      4: return dim_of(month, year);
      5: return 12;
      6: return 2099;
      default: return 0;
    endcase
  endfunction
  task automatic chk(input string n, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", n, got, exp);
    end
  endtask
  task automatic model_step();
    bit se, ie, de;
    int n;
    if (!reset_n) begin
      m_mode = 0; m_edit = 0; m_alarm = 0; m_cnt = 0; m_clamp = -1;
      m_wr = 0; m_sel = 0; m_data = 0; p_set = 0; p_incr = 0; p_dcr = 0;
    end else begin
      se = set && !p_set;
      ie = incr && !p_incr;
      de = dcr && !p_dcr;
      m_wr = 0;
      if (m_clamp >= 0) begin
        m_wr = 1; m_sel = 4; m_data = m_clamp; m_clamp = -1;
      end
      if (se) begin
        if (m_mode != 0) begin
          m_wr = 1; m_sel = m_mode; m_data = m_edit;
        end
        if (m_mode == 7) m_alarm = m_edit;
        if (m_mode == 5 && day > dim_of(m_edit, year)) m_clamp = dim_of(m_edit, year);
        if (m_mode == 6 && day > dim_of(month, m_edit)) m_clamp = dim_of(month, m_edit);
        m_mode = (m_mode + 1) % 8;
        if (m_mode != 0) m_edit = live_of(m_mode);
        m_cnt = 0;
      end else if (m_mode != 0) begin
        if (ie || de) m_cnt = 0;
        else if (tick_1hz) m_cnt++;
        if (m_cnt == 30) begin
          m_mode = 0; m_cnt = 0;
        end else if (ie != de) begin
          n = hi_of(m_mode) - lo_of(m_mode) + 1;
          m_edit = lo_of(m_mode) + (m_edit - lo_of(m_mode) + (ie ? 1 : n - 1)) % n;
        end
      end
      p_set = set; p_incr = incr; p_dcr = dcr;
    end
  endtask
  task automatic compare();
    chk("mode", mode, m_mode);
    chk("edit_val", edit_val, m_edit);
    chk("run_en", run_en, (m_mode >= 1 && m_mode <= 3) ? 0 : 1);
    chk("alarm_hours", alarm_hours, m_alarm);
    chk("wr_en", wr_en, m_wr);
    if (m_wr) begin
      chk("wr_sel", wr_sel, m_sel);
      chk("wr_data", wr_data, m_data);
    end
    if (wr_en) begin
      ws.push_back(wr_sel);
      wd.push_back(wr_data);
    end
  endtask
  task automatic cyc(input bit s, input bit i, input bit d, input bit t);
    set = s; incr = i; dcr = d; tick_1hz = t;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
  endtask
  task automatic press();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask
  task automatic incp();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
  endtask
  task automatic do_reset();
    reset_n = 0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    reset_n = 1;
  endtask
  initial begin
    do_reset();
    chk("rst_mode", mode, 0);
    chk("rst_run_en", run_en, 1);
    chk("rst_wr_sel", wr_sel, 0);
    chk("rst_wr_data", wr_data, 0);
    hours = 5; mins = 17; secs = 42; day = 31; month = 1; year = 2023;
    ws.delete(); wd.delete();
    repeat (8) press();
    chk("seq_mode", mode, 0);
    chk("seq_writes", ws.size(), 7);
    for (int i = 0; i < 7 && i < ws.size(); i++) begin
      chk("seq_sel", ws[i], i + 1);
      chk("seq_data", wd[i], seq_d[i]);
    end
    do_reset();
    hours = 22;
    press();
    chk("hr_load", edit_val, 22);
    incp(); chk("hr_inc1", edit_val, 23);
    incp(); chk("hr_wrap", edit_val, 0);
    incp(); chk("hr_inc3", edit_val, 1);
    ws.delete(); wd.delete();
    press();
    chk("hr_wr_n", ws.size(), 1);
    if (ws.size() == 1) begin
      chk("hr_wr_sel", ws[0], 1);
      chk("hr_wr_data", wd[0], 1);
    end
    do_reset();
    mins = 0;
    press(); press();
    cyc(0, 0, 1, 0); chk("min_dcr_wrap", edit_val, 59);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0); chk("min_both", edit_val, 59);
    cyc(0, 0, 0, 0);
    ws.delete(); wd.delete();
    cyc(1, 1, 0, 0);
    chk("set_wins_mode", mode, 3);
    chk("set_wins_edit", edit_val, 42);
    chk("set_wins_data", wd.size() > 0 ? wd[0] : -1, 59);
    cyc(0, 0, 0, 0);
    for (int y = 2023; y <= 2024; y++) begin
      do_reset();
      year = 12'(y); day = 31; month = 1;
      repeat (5) press();
      chk("mon_load", edit_val, 1);
      incp();
      ws.delete(); wd.delete();
      press();
      chk("clamp_n", ws.size(), 2);
      if (ws.size() == 2) begin
        chk("clamp_sel0", ws[0], 5);
        chk("clamp_data0", wd[0], 2);
        chk("clamp_sel1", ws[1], 4);
        chk("clamp_data1", wd[1], y == 2024 ? 29 : 28);
      end
    end
    do_reset();
    month = 4; day = 30; year = 2023;
    repeat (4) press();
    chk("day_load", edit_val, 30);
    incp(); chk("day_wrap", edit_val, 1);
    year = 2099;
    press(); press();
    chk("yr_mode", mode, 6);
    chk("yr_load", edit_val, 2099);
    incp(); chk("yr_wrap", edit_val, 2000);
    do_reset();
    repeat (3) press();
    ws.delete(); wd.delete();
    repeat (29) cyc(0, 0, 0, 1);
    chk("tmo_29", mode, 3);
    cyc(0, 0, 0, 1);
    chk("tmo_30", mode, 0);
    chk("tmo_edit", edit_val, 42);
    chk("tmo_nowr", ws.size(), 0);
    do_reset();
    repeat (7) press();
    chk("alm_mode", mode, 7);
    cyc(0, 0, 1, 0); chk("alm_dcr", edit_val, 23);
    cyc(0, 0, 0, 0);
    press();
    chk("alm_reg", alarm_hours, 23);
    press();
    ws.delete(); wd.delete();
    reset_n = 0;
    cyc(0, 0, 0, 0);
    chk("rst_edit_mode", mode, 0);
    chk("rst_edit_alarm", alarm_hours, 0);
    chk("rst_edit_nowr", ws.size(), 0);
    reset_n = 1;
    cyc(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
